hazard_ctrl_unit: RTL

//  Central stall/flush/forward controller for the 5-stage MIPS pipeline (IF, DEC, EX, MEM, WB).

---
 rtl/hazard_pkg.sv | 15 +
 rtl/md_busy_tracker.sv | 52 +++++
 rtl/hazard_ctrl_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//  FWD_*      : EX operand bypass select encodings
//  md_state_e : state of the multi-cycle MULT/DIV busy tracker
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // operand from MEM-stage ALU result
  localparam logic [1:0] FWD_WB  = 2'b10;  // operand from WB write data

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks the busy window of the multi-cycle MULT/DIV unit.
//  i_clk    : pipeline clock
//  i_rst_n  : async reset, active-low
//  i_start  : a MULT/DIV op is accepted into EX this cycle
//  o_busy   : HI/LO result not yet available
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LAT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_busy
);

  // Counter only needs to hold MD_LAT-1.
  localparam int unsigned CntW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MD_LAT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam bit HasBusy = (MD_LAT > 1);

  md_state_e       r_state;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        MD_IDLE: begin
          if (i_start && HasBusy) begin
            r_state <= MD_BUSY;
            r_cnt   <= CntInit;
          end
        end
        MD_BUSY: begin
          if (r_cnt == CntOne) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CntOne;
          end
        end
      endcase
    end
  end

  assign o_busy = (r_state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush/forward controller for a 5-stage pipeline (IF, DEC, EX, MEM, WB).
//  Inputs : DEC/EX/MEM/WB register indices and control bits, EX redirect
//  o_pc_stall/o_ifdec_stall : hold PC and FE_DEC register
//  o_ifdec_flush/o_decex_flush : squash FE_DEC / DEC_EX contents
//  o_fwd_a_sel/o_fwd_b_sel : EX operand bypass selects (see hazard_pkg)
//  o_md_busy : MULT/DIV result pending
//  o_stall_cnt/o_flush_cnt : saturating stall / redirect cycle counters
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MD_LAT     = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_dec_rs,
  input  logic [REG_ADDR_W-1:0] i_dec_rt,
  input  logic                  i_dec_uses_rs,
  input  logic                  i_dec_uses_rt,
  input  logic                  i_dec_is_md,
  input  logic                  i_dec_reads_hilo,
  input  logic [REG_ADDR_W-1:0] i_ex_rs,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic [REG_ADDR_W-1:0] i_ex_dst,
  input  logic                  i_ex_regwrite,
  input  logic                  i_ex_memread,
  input  logic                  i_ex_redirect,
  input  logic [REG_ADDR_W-1:0] i_mem_dst,
  input  logic                  i_mem_regwrite,
  input  logic [REG_ADDR_W-1:0] i_wb_dst,
  input  logic                  i_wb_regwrite,
  output logic                  o_pc_stall,
  output logic                  o_ifdec_stall,
  output logic                  o_ifdec_flush,
  output logic                  o_decex_flush,
  output logic [1:0]            o_fwd_a_sel,
  output logic [1:0]            o_fwd_b_sel,
  output logic                  o_md_busy,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  logic             w_md_busy;
  logic             w_load_use;
  logic             w_md_hold;
  logic             w_stall;
  logic             w_md_start;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  md_busy_tracker #(
    .MD_LAT (MD_LAT)
  ) u_md_busy_tracker (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_md_start),
    .o_busy  (w_md_busy)
  );

  assign w_load_use = i_ex_memread && i_ex_regwrite && (i_ex_dst != '0) &&
                      ((i_dec_uses_rs && (i_dec_rs == i_ex_dst)) ||
                       (i_dec_uses_rt && (i_dec_rt == i_ex_dst)));
  assign w_md_hold  = w_md_busy && (i_dec_reads_hilo || i_dec_is_md);

  // Redirect squashes DEC, so any stall request from DEC is moot.
  assign w_stall    = !i_ex_redirect && (w_md_hold || w_load_use);
  assign w_md_start = i_dec_is_md && !i_ex_redirect && !w_stall;

  always_comb begin
    o_pc_stall    = w_stall;
    o_ifdec_stall = w_stall;
    o_ifdec_flush = i_ex_redirect;
    o_decex_flush = i_ex_redirect || w_stall;
  end

  // MEM result is younger than WB data, so it wins; r0 is hardwired zero.
  always_comb begin
    o_fwd_a_sel = FWD_REG;
    if (i_mem_regwrite && (i_mem_dst != '0) && (i_mem_dst == i_ex_rs)) begin
      o_fwd_a_sel = FWD_MEM;
    end else if (i_wb_regwrite && (i_wb_dst != '0) && (i_wb_dst == i_ex_rs)) begin
      o_fwd_a_sel = FWD_WB;
    end
  end

  always_comb begin
    o_fwd_b_sel = FWD_REG;
    if (i_mem_regwrite && (i_mem_dst != '0) && (i_mem_dst == i_ex_rt)) begin
      o_fwd_b_sel = FWD_MEM;
    end else if (i_wb_regwrite && (i_wb_dst != '0) && (i_wb_dst == i_ex_rt)) begin
      o_fwd_b_sel = FWD_WB;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (i_ex_redirect && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_md_busy   = w_md_busy;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule
